// File: rtl/lfsr_gen.sv
// lfsr_gen: maximal-length XNOR Fibonacci LFSR, 3..16 bits.
// Step enable, guarded seed load, narrow random slice, wrap pulse.
module lfsr_gen #(
    parameter int WIDTH = 10,
    parameter int OUT_W = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Seed,
    output logic [WIDTH-1:0] Q,
    output logic [OUT_W-1:0] Rand,
    output logic             Wrap,
    output logic             SeedErr
);

    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be 3..16");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
        $error("lfsr_gen: OUT_W must be 1..WIDTH");
    end

    // Tap masks, bit index = tap - 1.
    function automatic logic [15:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      TAP16 = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS  = TAP16[WIDTH-1:0];

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] q_step;
    logic             fb;
    logic             seed_lock;

    // Next state for one shift; all-ones seed is the lock-up value.
    always_comb begin
        fb        = ~^(Q & TAPS);
        q_step    = {Q[WIDTH-2:0], fb};
        seed_lock = &Seed;
    end

    // State, start capture and one-cycle status pulses.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Q       <= '0;
            start   <= '0;
            Wrap    <= 1'b0;
            SeedErr <= 1'b0;
        end else if (Load) begin
            Wrap <= 1'b0;
            if (seed_lock) begin
                Q       <= '0;
                start   <= '0;
                SeedErr <= 1'b1;
            end else begin
                Q       <= Seed;
                start   <= Seed;
                SeedErr <= 1'b0;
            end
        end else if (Enable) begin
            Q       <= q_step;
            Wrap    <= (q_step == start);
            SeedErr <= 1'b0;
        end else begin
            Wrap    <= 1'b0;
            SeedErr <= 1'b0;
        end
    end

    assign Rand = Q[OUT_W-1:0];

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and random checks of two lfsr_gen instances
// (10-bit and 4-bit) against a tap-list reference model.
module tb_lfsr_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ld;
    logic [9:0] seed;

    logic [9:0] q10;
    logic [1:0] r10;
    logic       w10;
    logic       e10;
    logic [3:0] q4;
    logic [1:0] r4;
    logic       w4;
    logic       e4;

    int n_tests;
    int n_fail;

    // Reference model state, one set per instance.
    int m_q10, m_st10, m_w10, m_e10;
    int m_q4, m_st4, m_w4, m_e4;

    lfsr_gen #(.WIDTH(10), .OUT_W(2)) d10 (
        .Clock(clk), .Reset(rst), .Enable(en), .Load(ld),
        .Seed(seed), .Q(q10), .Rand(r10), .Wrap(w10), .SeedErr(e10)
    );

    lfsr_gen #(.WIDTH(4), .OUT_W(2)) d4 (
        .Clock(clk), .Reset(rst), .Enable(en), .Load(ld),
        .Seed(seed[3:0]), .Q(q4), .Rand(r4), .Wrap(w4), .SeedErr(e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One LFSR step from the documented tap list: feedback is 1 when
    // an even number of tap bits are set.
    function automatic int ref_next(input int w, input int q);
        int t[4];
        int n;
        int ones;
        int fb;
        t = '{0, 0, 0, 0};
        n = 0;
        case (w)
            4:  begin t = '{4, 3, 0, 0}; n = 2; end
            10: begin t = '{10, 7, 0, 0}; n = 2; end
            default: n = 0;
        endcase
        ones = 0;
        for (int k = 0; k < n; k++) ones += (q >> (t[k] - 1)) & 1;
        fb = ((ones % 2) == 0) ? 1 : 0;
        return ((q * 2) + fb) % (1 << w);
    endfunction

    task automatic model(input int w, input int sd,
                         inout int q, inout int st,
                         inout int wr, inout int er);
        int all1;
        all1 = (1 << w) - 1;
        if (!rst) begin
            q = 0; st = 0; wr = 0; er = 0;
        end else if (ld) begin
            wr = 0;
            if (sd == all1) begin
                q = 0; st = 0; er = 1;
            end else begin
                q = sd; st = sd; er = 0;
            end
        end else if (en) begin
            q = ref_next(w, q);
            wr = (q == st) ? 1 : 0;
            er = 0;
        end else begin
            wr = 0; er = 0;
        end
    endtask

    // Advance one edge, update models, sample and compare at +1.
    task automatic tick();
        @(posedge clk);
        model(10, int'(seed), m_q10, m_st10, m_w10, m_e10);
        model(4, int'(seed[3:0]), m_q4, m_st4, m_w4, m_e4);
        #1;
        check("q10", int'(q10), m_q10);
        check("rand10", int'(r10), m_q10 % 4);
        check("wrap10", int'(w10), m_w10);
        check("err10", int'(e10), m_e10);
        check("q4", int'(q4), m_q4);
        check("rand4", int'(r4), m_q4 % 4);
        check("wrap4", int'(w4), m_w4);
        check("err4", int'(e4), m_e4);
    endtask

    initial begin
        bit seen10[1024];
        bit seen4[16];
        int first_wrap;
        int wraps;
        int repeats;
        int prev;
        int en_pat[4];

        n_tests = 0;
        n_fail  = 0;
        m_q10 = 0; m_st10 = 0; m_w10 = 0; m_e10 = 0;
        m_q4 = 0; m_st4 = 0; m_w4 = 0; m_e4 = 0;
        rst = 1'b0; en = 1'b0; ld = 1'b0; seed = '0;
        #1;

        // 1: reset, then shift in ones.
        tick();
        tick();
        check("t1_reset_q", int'(q10), 0);
        rst = 1'b1; en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t1_seq", int'(q10), (i <= 7) ? ((1 << i) - 1) : 'h0FE);
        end

        // 2: full period from reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        foreach (seen10[i]) seen10[i] = 1'b0;
        seen10[0] = 1'b1;
        first_wrap = 0; wraps = 0; repeats = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (i < 1023) begin
                if (seen10[q10] || q10 == 10'h3FF) repeats++;
                seen10[q10] = 1'b1;
            end
            if (i == 1023) check("t2_q_at_1023", int'(q10), 0);
            if (w10) begin
                wraps++;
                if (first_wrap == 0) first_wrap = i;
            end
        end
        check("t2_first_wrap", first_wrap, 1023);
        check("t2_wrap_count", wraps, 1);
        check("t2_repeats", repeats, 0);

        // 3: lock-up seed, then load beats enable.
        en = 1'b0; ld = 1'b1; seed = 10'h3FF;
        tick();
        check("t3_err", int'(e10), 1);
        check("t3_q", int'(q10), 0);
        en = 1'b1; seed = 10'h155;
        tick();
        check("t3_load_q", int'(q10), 'h155);
        check("t3_err_clr", int'(e10), 0);
        ld = 1'b0; en = 1'b0;
        tick();

        // 4: 4-bit period from seed 0x5.
        ld = 1'b1; seed = 10'h005;
        tick();
        ld = 1'b0; en = 1'b1;
        foreach (seen4[i]) seen4[i] = 1'b0;
        repeats = 0; wraps = 0; first_wrap = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (seen4[q4] || q4 == 4'hF) repeats++;
            seen4[q4] = 1'b1;
            if (w4) begin
                wraps++;
                first_wrap = i;
            end
        end
        check("t4_repeats", repeats, 0);
        check("t4_wraps", wraps, 1);
        check("t4_wrap_edge", first_wrap, 15);
        check("t4_q_end", int'(q4), 5);

        // 5: enable pattern 1,0,0,1.
        en_pat = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            prev = int'(q10);
            en = en_pat[i][0];
            tick();
            check("t5_q", int'(q10), en_pat[i] ? ref_next(10, prev) : prev);
            check("t5_wrap", int'(w10), 0);
            check("t5_err", int'(e10), 0);
        end

        // 6: reset mid-run with enable and load high.
        en = 1'b1;
        repeat (5) tick();
        rst = 1'b0; ld = 1'b1; seed = 10'h0AA;
        tick();
        check("t6_q", int'(q10), 0);
        check("t6_wrap", int'(w10), 0);
        check("t6_err", int'(e10), 0);
        rst = 1'b1; ld = 1'b0;
        tick();
        check("t6_restart", int'(q10), 1);
        first_wrap = 0;
        for (int i = 2; i <= 1023; i++) begin
            tick();
            if (w10 && first_wrap == 0) first_wrap = i;
        end
        check("t6_wrap_step", first_wrap, 1023);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 63) != 0);
            ld   = ($urandom_range(0, 7) == 0);
            en   = $urandom_range(0, 1) == 1;
            seed = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
            if ($urandom_range(0, 7) == 0) seed[3:0] = 4'hF;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised maximal-length XNOR Fibonacci LFSR for pseudo-random step/arrow selection in the game logic.
- Width is selectable from 3 to 16 bits, with a built-in maximal-length tap table.
- Adds features the fixed 10-bit generator lacks: step enable, synchronous seed load with lock-up guard, a narrow random output slice, and a period-wrap pulse.
- Sits between the game timing FSM (drives Enable/Load) and the pattern selector (consumes Rand/Wrap).

Parameters:
- WIDTH, 10, LFSR length in bits; legal range 3..16; any other value is an elaboration error.
- OUT_W, 2, width of Rand output; legal range 1..WIDTH.

Ports:
- Clock  input  1  rising-edge system clock.
- Reset  input  1  synchronous, active-low reset; sampled on Clock rising edge.
- Enable  input  1  advance the LFSR one step this cycle.
- Load  input  1  load Seed into the LFSR this cycle.
- Seed  input  WIDTH  seed value, used only when Load=1.
- Q  output  WIDTH  current LFSR state.
- Rand  output  OUT_W  Q[OUT_W-1:0].
- Wrap  output  1  one-cycle pulse: a step just returned Q to the start state.
- SeedErr  output  1  one-cycle pulse: the loaded Seed was the lock-up value.

Behaviour:
- Single clock domain. Interface decided: one clock, Clock; reset is synchronous and active-low, named Reset.
- Reset values (Reset=0 at an edge): Q=0, Start=0, Wrap=0, SeedErr=0.
- Priority per edge: Reset > Load > Enable > hold.
- Feedback bit fb = XNOR of the tap bits of Q. Taps are 1-indexed; bit index = tap-1.
- Tap table:
  - 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4
  - 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1
  - 14:14,5,3,1; 15:15,14; 16:16,15,13,4
- Step (Enable=1, Load=0): Q <= {Q[WIDTH-2:0], fb}. Bit 0 receives fb; each bit i takes Q[i-1].
- Period is 2^WIDTH-1 steps. All-ones is the XNOR lock-up state and is never reached from any legal state.
- Load=1:
  - Seed is not all-ones: Q <= Seed, Start <= Seed, SeedErr <= 0.
  - Seed is all-ones: Q <= 0, Start <= 0, SeedErr <= 1.
  - No step occurs in a load cycle, even if Enable=1.
- Start is an internal register holding the state captured at the last reset or load.
- Wrap:
  - Registered. Wrap <= 1 on a step edge whose next Q equals Start; Wrap <= 0 on every other edge.
  - Wrap is therefore high in the same cycle Q first shows Start again.
  - Load and reset edges never set Wrap.
- SeedErr is high only for the cycle after the offending load.
- Enable=0 and Load=0: Q, Start hold; Wrap=0, SeedErr=0.
- Reset mid-sequence: the next edge forces reset values regardless of Enable/Load.
- Rand is combinational from Q, with no extra latency.
- Latency: Q reflects a step or load one edge after Enable/Load is sampled.

Test Plan:
1. WIDTH=10, Reset=0 for 2 cycles, release, Enable=1 -> Q after successive edges: 0x000, 0x001, 0x003, 0x007, ..., 0x07F, then 0x0FE; Rand follows Q[1:0].
2. WIDTH=10, Enable=1 continuously from reset -> Wrap=0 for steps 1..1022; Q=0x000 and Wrap=1 exactly at step 1023; Wrap=0 at step 1024; no state repeats before step 1023.
3. WIDTH=10, Load=1 with Seed=0x3FF -> Q=0x000, SeedErr=1 for one cycle. Then Load=1 with Seed=0x155 and Enable=1 in the same cycle -> Q=0x155 (no step), SeedErr=0.
4. WIDTH=4, OUT_W=2, load Seed=0x5, then Enable=1 for 15 edges -> 15 distinct states, none equal to 0xF; Wrap=1 only on edge 15, with Q=0x5.
5. Enable toggled 1,0,0,1 -> Q advances only on edges with Enable=1; holds otherwise; Wrap/SeedErr stay 0.
6. Reset=0 asserted mid-run with Enable=1 and Load=1 -> next edge gives Q=0, Wrap=0, SeedErr=0. After release, the sequence restarts at 0x001 and a wrap is counted from state 0.
